// File: rtl/wb_fifo_xfer_ctrl_pkg.sv
// Shared types and constants for the FIFO-to-Wishbone transfer controller.
package wb_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL,
      ST_RD,
      ST_WR,
      ST_DONE
   } xfer_state_e;

   localparam logic [31:0] STAT_ADR_DEF = 32'h0100_0000;
   localparam logic [31:0] DATA_ADR_DEF = 32'h0000_0000;

   // The FIFO fill level sits in the status word starting at this bit.
   localparam int STAT_LVL_LSB = 0;

endpackage

// File: rtl/wb_fifo_xfer_ctrl_if.sv
// Wishbone classic bus bundle; signal suffixes are from the master's point of view.
interface wb_fifo_xfer_ctrl_if;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic [3:0]  sel_o;
   logic        we_o;
   logic        cyc_o;
   logic        stb_o;
   logic        ack_i;
   logic        err_i;

   modport master (
      output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
      input  dat_i, ack_i, err_i
   );

   modport slave (
      input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
      output dat_i, ack_i, err_i
   );
endinterface

// File: rtl/wb_fifo_xfer_ctrl_master_port.sv
// wb_master_port: one Wishbone classic-cycle master. A request while idle
// registers address/data and raises cyc/stb; both drop the cycle after ack or err.
module wb_master_port (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [31:0]                adr_i,
   input  logic [31:0]                dat_i,
   output logic                       ack_o,
   output logic                       err_o,
   output logic [31:0]                rdat_o,
   wb_fifo_xfer_ctrl_if.master        wb
);

   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;

   // Start a cycle on request, end it on any response
   always_comb begin
      cyc_d = cyc_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;
      sel_d = sel_q;
      if (cyc_q) begin
         if (wb.ack_i || wb.err_i) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
         end
      end else if (req_i) begin
         cyc_d = 1'b1;
         we_d  = we_i;
         adr_d = adr_i;
         dat_d = dat_i;
         sel_d = 4'hF;
      end
   end

   // Bus-side registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
         sel_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         we_q  <= we_d;
         adr_q <= adr_d;
         dat_q <= dat_d;
         sel_q <= sel_d;
      end
   end

   assign wb.cyc_o = cyc_q;
   assign wb.stb_o = cyc_q;
   assign wb.we_o  = we_q;
   assign wb.adr_o = adr_q;
   assign wb.dat_o = dat_q;
   assign wb.sel_o = sel_q;

   // An error wins over a simultaneous ack
   assign err_o  = cyc_q & wb.err_i;
   assign ack_o  = cyc_q & wb.ack_i & ~wb.err_i;
   assign rdat_o = wb.dat_i;

endmodule

// File: rtl/wb_fifo_xfer_ctrl.sv
// wb_fifo_xfer_ctrl: moves len_i words from a status-polled FIFO read port to
// consecutive destination addresses, one status read per batch of available words.
// Optional feature: define WB_FIFO_XFER_TIMEOUT_EN to abort after TIMEOUT
// consecutive polls that yield no credit.
//
// state | meaning
// IDLE  | waiting for start_i
// POLL  | reading FIFO status to learn how many words may be taken
// RD    | popping one word into the holding register
// WR    | writing the holding register to the destination
// DONE  | one-cycle completion / abort pulse
module wb_fifo_xfer_ctrl
   import wb_fifo_pkg::*;
#(
   parameter int          FIFO_ADR_W = 9,
   parameter int          LEN_W      = 16,
   parameter logic [31:0] STAT_ADR   = STAT_ADR_DEF,
   parameter logic [31:0] DATA_ADR   = DATA_ADR_DEF,
   parameter int          TIMEOUT    = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [LEN_W-1:0]    len_i,
   input  logic [31:0]         dst_adr_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   wb_fifo_xfer_ctrl_if.master src_wb,
   wb_fifo_xfer_ctrl_if.master dst_wb
);

   localparam int LVL_W = FIFO_ADR_W + 1;

   xfer_state_e      state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] credit_q, credit_d;
   logic [31:0]      dst_adr_q, dst_adr_d;
   logic [31:0]      hold_q, hold_d;
   logic             abort_q, abort_d;

   logic             src_req, src_ack, src_err;
   logic             dst_req, dst_ack, dst_err;
   logic [31:0]      src_adr, src_rdat, dst_rdat_unused;
   logic [LVL_W-1:0] level;
   logic [LEN_W-1:0] credit_new;
   logic             poll_expired;

   // Credit never exceeds what is still owed for this transfer
   assign level      = src_rdat[STAT_LVL_LSB +: LVL_W];
   assign credit_new = (32'(level) < 32'(rem_q)) ? LEN_W'(level) : rem_q;

`ifdef WB_FIFO_XFER_TIMEOUT_EN
   logic [31:0] poll_cnt_q, poll_cnt_d;

   // Down-counter of empty polls still tolerated; reloaded on start and on any credit
   always_comb begin
      poll_cnt_d = poll_cnt_q;
      if (state_q == ST_IDLE) begin
         poll_cnt_d = 32'(TIMEOUT - 1);
      end else if (state_q == ST_POLL && src_ack) begin
         if (credit_new != '0)
            poll_cnt_d = 32'(TIMEOUT - 1);
         else if (poll_cnt_q != '0)
            poll_cnt_d = poll_cnt_q - 32'd1;
      end
   end

   // Poll counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) poll_cnt_q <= '0;
      else       poll_cnt_q <= poll_cnt_d;
   end

   assign poll_expired = (poll_cnt_q == '0);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign poll_expired   = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         credit_q  <= '0;
         dst_adr_q <= '0;
         hold_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         credit_q  <= credit_d;
         dst_adr_q <= dst_adr_d;
         hold_q    <= hold_d;
         abort_q   <= abort_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      credit_d  = credit_q;
      dst_adr_d = dst_adr_q;
      hold_d    = hold_q;
      abort_d   = abort_q;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (start_i) begin
               rem_d     = len_i;
               credit_d  = '0;
               dst_adr_d = dst_adr_i;
               state_d   = (len_i == '0) ? ST_DONE : ST_POLL;
            end
         end
         ST_POLL: begin
            if (src_err) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (src_ack) begin
               credit_d = credit_new;
               if (credit_new != '0) begin
                  state_d = ST_RD;
               end else if (poll_expired) begin
                  abort_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RD: begin
            if (src_err) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (src_ack) begin
               hold_d   = src_rdat;
               credit_d = credit_q - LEN_W'(1);
               rem_d    = rem_q - LEN_W'(1);
               state_d  = ST_WR;
            end
         end
         ST_WR: begin
            if (dst_err) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (dst_ack) begin
               dst_adr_d = dst_adr_q + 32'd4;
               if (credit_q != '0)   state_d = ST_RD;
               else if (rem_q != '0) state_d = ST_POLL;
               else                  state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus requests and status outputs decoded from state
   always_comb begin
      src_req = 1'b0;
      src_adr = DATA_ADR;
      dst_req = 1'b0;
      busy_o  = (state_q != ST_IDLE);
      done_o  = (state_q == ST_DONE);
      err_o   = (state_q == ST_DONE) && abort_q;
      case (state_q)
         ST_POLL: begin
            src_req = 1'b1;
            src_adr = STAT_ADR;
         end
         ST_RD:   src_req = 1'b1;
         ST_WR:   dst_req = 1'b1;
         default: ;
      endcase
   end

   wb_master_port u_src_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (src_req),
      .we_i   (1'b0),
      .adr_i  (src_adr),
      .dat_i  (32'h0),
      .ack_o  (src_ack),
      .err_o  (src_err),
      .rdat_o (src_rdat),
      .wb     (src_wb)
   );

   wb_master_port u_dst_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (dst_req),
      .we_i   (1'b1),
      .adr_i  (dst_adr_q),
      .dat_i  (hold_q),
      .ack_o  (dst_ack),
      .err_o  (dst_err),
      .rdat_o (dst_rdat_unused),
      .wb     (dst_wb)
   );

endmodule
